gate_vector_checker: RTL
========================

Name: gate_vector_checker

Overview:
Self-checking stimulus stage for the 2-input gate blocks (or_gate and its siblings). On a start pulse it walks the four input vectors {a,b} = 00, 01, 10, 11 into a gate DUT, holds each vector for a programmable settle time, and samples the DUT output y. Each sample is compared against a parameterised truth table, and the block reports pass/fail, an error count and a per-vector mismatch mask. It sits directly upstream of the gate, drives the gate's a/b inputs and consumes its y output.

Parameters:
HOLD_CYCLES, 2, cycles each vector is driven before the sample cycle; legal range 1..15
TRUTH, 4'b1110, expected y indexed by {a,b} (bit 0 = vector 00); 4'b1110 = OR, 4'b1000 = AND
LOOP, 0, 1 = restart the sweep automatically after each completion

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset
start  in  1  begin sweep; sampled only in IDLE
y  in  1  DUT output, combinational from a/b
a  out  1  DUT input a (registered)
b  out  1  DUT input b (registered)
busy  out  1  high while a sweep is running (DRIVE/CHECK)
done  out  1  one-cycle pulse at end of sweep
pass  out  1  1 if the last sweep had zero mismatches; held until the next start
err_count  out  3  number of mismatching vectors in the last sweep, 0..4
err_mask  out  4  bit v set if vector v mismatched

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, err_mask=0, vec=0, hold_cnt=0.
- A reset asserted mid-sweep aborts the sweep. All reset values apply at that edge, and no done pulse is produced.
- State machine: IDLE, DRIVE, CHECK, DONE.
- IDLE, with start=1 at edge T:
  - vec=0; {a,b}=00
  - err_count=0; err_mask=0; pass=0
  - hold_cnt=0; state=DRIVE; busy=1 from T
- DRIVE:
  - {a,b}={vec[1],vec[0]}; hold_cnt increments each cycle
  - when hold_cnt==HOLD_CYCLES-1, go to CHECK
- CHECK (one cycle):
  - register compare of y against TRUTH[vec]
  - on mismatch: err_count+1 and err_mask[vec]=1
  - if vec==3, go to DONE
  - else vec+1, {a,b} updated at the same edge, hold_cnt=0, go to DRIVE
- Each vector is therefore presented for HOLD_CYCLES+1 cycles. y is sampled in the last of those cycles.
- DONE (one cycle):
  - done=1, busy=0
  - pass=(err_count==0), using the final count including the last CHECK
  - next state is IDLE when LOOP=0
  - when LOOP=1, next state is DRIVE with vec, err_count and err_mask cleared; pass holds its value until the next DONE
- Latency: busy is high for 4*(HOLD_CYCLES+1) cycles; done asserts on the following cycle. With HOLD_CYCLES=2, busy lasts 12 cycles and done is high in cycle 13 after the start edge.
- start is ignored outside IDLE, including a start coincident with DONE.
- err_count cannot exceed 4, so no saturation logic is needed.
- a and b stay at their last vector (11) after DONE until the next start or reset.
- err_count and err_mask stay stable from DONE until the next start.

Test Plan:
- Correct or_gate DUT, TRUTH=4'b1110, HOLD_CYCLES=2, start pulse -> a/b sequence 00,01,10,11 with each vector held 3 cycles; busy high 12 cycles; done pulse at cycle 13; pass=1, err_count=0, err_mask=0000.
- y tied to 0, TRUTH=4'b1110 -> err_count=3, err_mask=1110, pass=0 at done.
- AND gate DUT with TRUTH=4'b1110 -> err_count=2, err_mask=0110, pass=0.
- start re-pulsed at cycles 4 and 13 (the DONE cycle) -> no restart, same done timing; a third start in IDLE clears err_mask and sweeps again.
- rst asserted at cycle 5 of a sweep -> next edge all outputs at reset values, no done pulse; a fresh start then completes normally with pass=1.
- HOLD_CYCLES=1, LOOP=1 -> busy segments of 8 cycles with done every 9th cycle, repeating; pass stays 1 across loops with a correct OR DUT.

Source files
------------

// File: rtl/gate_vector_checker.sv
// Stimulus/check stage for 2-input gate blocks: sweeps {a,b} through 00..11,
// samples y after a settle time and scores it against a truth table.
module gate_vector_checker #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [3:0]  TRUTH       = 4'b1110,
  parameter bit          LOOP        = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_mask
);

  localparam int unsigned HOLD_W = 4;
  localparam int unsigned VEC_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(3);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [VEC_W-1:0]  vec, vec_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [CNT_W-1:0]  err_count_nxt;
  logic [3:0]        err_mask_nxt;
  logic              mismatch_c;

  assign mismatch_c = (y != TRUTH[vec]);

  // Next-state and next-output logic; every register holds unless changed below.
  always_comb begin
    state_nxt     = state;
    vec_nxt       = vec;
    hold_cnt_nxt  = hold_cnt;
    a_nxt         = a;
    b_nxt         = b;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    pass_nxt      = pass;
    err_count_nxt = err_count;
    err_mask_nxt  = err_mask;

    case (state)
      ST_IDLE: begin
        if (start) begin
          vec_nxt       = '0;
          a_nxt         = 1'b0;
          b_nxt         = 1'b0;
          err_count_nxt = '0;
          err_mask_nxt  = '0;
          pass_nxt      = 1'b0;
          hold_cnt_nxt  = '0;
          busy_nxt      = 1'b1;
          state_nxt     = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (mismatch_c) begin
          err_count_nxt     = err_count + CNT_W'(1);
          err_mask_nxt[vec] = 1'b1;
        end
        if (vec == VEC_LAST) begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          // Includes the mismatch from this final sample.
          pass_nxt  = (err_count_nxt == CNT_W'(0));
          state_nxt = ST_DONE;
        end else begin
          vec_nxt      = vec + VEC_W'(1);
          a_nxt        = vec_nxt[1];
          b_nxt        = vec_nxt[0];
          hold_cnt_nxt = '0;
          state_nxt    = ST_DRIVE;
        end
      end

      ST_DONE: begin
        if (LOOP) begin
          // pass is left alone so it reflects the previous sweep until the next DONE.
          vec_nxt       = '0;
          a_nxt         = 1'b0;
          b_nxt         = 1'b0;
          err_count_nxt = '0;
          err_mask_nxt  = '0;
          hold_cnt_nxt  = '0;
          busy_nxt      = 1'b1;
          state_nxt     = ST_DRIVE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      vec       <= '0;
      hold_cnt  <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      err_mask  <= '0;
    end else begin
      state     <= state_nxt;
      vec       <= vec_nxt;
      hold_cnt  <= hold_cnt_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= err_count_nxt;
      err_mask  <= err_mask_nxt;
    end
  end

endmodule
